dequantize: RTL and testbench
=============================

DEQUANTIZE -- requirements
Module: dequantize

Interface
REQ-001 SHALL have parameter WIDTH_INPUT, default 8: signed quantized input width.
REQ-002 SHALL have parameter WIDTH_OUTPUT, default 32: signed dequantized output width.
REQ-003 SHALL have parameter NUM_CALCULATE, default 8: outputs per burst; legal range 2 or more.
REQ-004 SHALL have parameter SCALING_FACTOR, default 2408: unsigned scale, fixed-point with FRAC_BITS fraction bits.
REQ-005 SHALL have parameter FRAC_BITS, default 0: fraction bits of SCALING_FACTOR.
REQ-006 SHALL have port clk_i  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port rstn_i  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port i_dq_valid  input  1  din_i carries a valid element this cycle.
REQ-009 SHALL have port i_clear  input  1  synchronous flush of pipeline and burst counter.
REQ-010 SHALL have port din_i  input  WIDTH_INPUT  signed quantized element.
REQ-011 SHALL have port o_dqout  output  WIDTH_OUTPUT  signed dequantized element.
REQ-012 SHALL have port o_dqvalid  output  1  o_dqout valid this cycle.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse on last output of a burst.

Function
REQ-014 SHALL be a 2-stage pipeline: stage 1 registers din_i and i_dq_valid; stage 2 registers the scaled result; o_dqvalid follows i_dq_valid by exactly 2 cycles.
REQ-015 SHALL accept a new element every cycle; gaps in i_dq_valid SHALL propagate as gaps in o_dqvalid; there is no backpressure.
REQ-016 SHALL compute the full-precision product P = din_i * SCALING_FACTOR, signed, width WIDTH_INPUT + 32 bits, with no intermediate overflow.
REQ-017 When FRAC_BITS = 0, the result SHALL be P exactly.
REQ-018 When FRAC_BITS > 0, the result SHALL be P / 2^FRAC_BITS rounded half away from zero: add 2^(FRAC_BITS-1) to the magnitude, then truncate.
REQ-019 SHALL hold o_dqout at 0 whenever o_dqvalid is 0; output capture is gated by stage-1 valid.
REQ-020 SHALL keep a burst counter from 0 to NUM_CALCULATE-1 that increments on each cycle o_dqvalid is 1.
REQ-021 SHALL assert done_o in the same cycle as the o_dqvalid that carries counter value NUM_CALCULATE-1; the counter then wraps to 0.
REQ-022 done_o SHALL never be 1 while o_dqvalid is 0.
REQ-023 i_clear = 1 SHALL zero both stage valids, o_dqout, done_o and the counter on the next edge.
REQ-024 When i_clear and i_dq_valid are both 1, i_clear SHALL win and the element SHALL be dropped.
REQ-025 Back-to-back bursts SHALL be supported with no idle cycle; element NUM_CALCULATE+1 starts count 0.

Reset
REQ-026 rstn_i low SHALL asynchronously force o_dqout = 0, o_dqvalid = 0, done_o = 0, counter = 0, and both stage registers to 0.
REQ-027 Reset asserted mid-burst SHALL discard the partial burst; the first valid after release SHALL be count 0.
REQ-028 The first o_dqvalid after reset release SHALL occur no earlier than 2 edges after the first accepted i_dq_valid.

Configuration
REQ-029 Macro DEQUANTIZE_SAT_EN defined: the result SHALL saturate to the signed WIDTH_OUTPUT range, positive limit 2^(WIDTH_OUTPUT-1)-1 and negative limit -2^(WIDTH_OUTPUT-1).
REQ-030 Macro DEQUANTIZE_SAT_EN undefined: the result SHALL be truncated to its low WIDTH_OUTPUT bits (two's-complement wrap), with no saturation logic present.

Verification
REQ-031 Defaults (FRAC_BITS 0, SCALING_FACTOR 2408): din_i = 5 at cycle 0 -> o_dqout = 12040 with o_dqvalid at cycle 2; din_i = -128 -> -308224.
REQ-032 FRAC_BITS = 4, SCALING_FACTOR = 40: din_i = 3 -> 8; din_i = -3 -> -8; din_i = 2 -> 5.
REQ-033 Burst test: 8 valids with 2 idle gaps inserted -> exactly 8 o_dqvalid; done_o only on the 8th; back-to-back second burst -> done_o on the 16th.
REQ-034 WIDTH_OUTPUT = 16, din_i = 127, SCALING_FACTOR = 2408 -> 32767 with DEQUANTIZE_SAT_EN; -21864 without it. din_i = -128 with the macro -> -32768.
REQ-035 Reset or clear mid-burst: assert rstn_i = 0 asynchronously (or i_clear = 1) after 5 valids -> all outputs 0 immediately (next edge for clear); the following 8 valids -> done_o on the 8th.
REQ-036 i_clear and i_dq_valid both high in the same cycle -> no o_dqvalid 2 cycles later, and the counter is unchanged from 0.

Source files
------------

// File: rtl/dequantize.sv
// Two-stage dequantizer: scales signed quantized elements by a fixed-point constant
// and flags the last element of each NUM_CALCULATE burst. Optional macro: DEQUANTIZE_SAT_EN.
module dequantize #(
    parameter int unsigned WIDTH_INPUT    = 8,
    parameter int unsigned WIDTH_OUTPUT   = 32,
    parameter int unsigned NUM_CALCULATE  = 8,
    parameter int unsigned SCALING_FACTOR = 2408,
    parameter int unsigned FRAC_BITS      = 0
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           i_dq_valid,
    input  logic                           i_clear,
    input  logic signed [WIDTH_INPUT-1:0]  din_i,
    output logic signed [WIDTH_OUTPUT-1:0] o_dqout,
    output logic                           o_dqvalid,
    output logic                           done_o
);

    localparam int unsigned PW = WIDTH_INPUT + 32;
    localparam int unsigned RW = PW + 1;
    localparam int unsigned CW = (NUM_CALCULATE > 1) ? $clog2(NUM_CALCULATE) : 1;
    localparam logic [CW-1:0] LAST  = CW'(NUM_CALCULATE - 1);
    localparam logic [31:0]   SCALE = SCALING_FACTOR;

    logic                          s1_valid;
    logic signed [WIDTH_INPUT-1:0] s1_data;
    logic [CW-1:0]                 cnt;

    logic signed [PW-1:0]           din_ext;
    logic signed [PW-1:0]           scale_ext;
    logic signed [PW-1:0]           prod;
    logic signed [RW-1:0]           rounded;
    logic signed [WIDTH_OUTPUT-1:0] result;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (i_clear) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= i_dq_valid;
            if (i_dq_valid) begin
                s1_data <= din_i;
            end
        end
    end

    // Unsigned scale is zero-extended so the signed product never overflows PW bits.
    assign din_ext   = {{32{s1_data[WIDTH_INPUT-1]}}, s1_data};
    assign scale_ext = {{WIDTH_INPUT{1'b0}}, SCALE};
    assign prod      = din_ext * scale_ext;

    generate
        if (FRAC_BITS == 0) begin : g_exact
            assign rounded = {prod[PW-1], prod};
        end else begin : g_round
            localparam logic [RW-1:0] HALF = RW'(1) << (FRAC_BITS - 1);
            logic signed [RW-1:0] p_ext;
            logic        [RW-1:0] mag;
            logic        [RW-1:0] mag_r;
            logic                 neg;

            // Round half away from zero by rounding the magnitude, then restoring sign.
            assign p_ext   = {prod[PW-1], prod};
            assign neg     = prod[PW-1];
            assign mag     = neg ? -p_ext : p_ext;
            assign mag_r   = (mag + HALF) >> FRAC_BITS;
            assign rounded = neg ? -mag_r : mag_r;
        end
    endgenerate

`ifdef DEQUANTIZE_SAT_EN
    generate
        if (WIDTH_OUTPUT >= RW) begin : g_wide
            assign result = WIDTH_OUTPUT'(rounded);
        end else begin : g_sat
            localparam logic signed [RW-1:0] SAT_MAX =
                {{(RW - WIDTH_OUTPUT + 1){1'b0}}, {(WIDTH_OUTPUT - 1){1'b1}}};
            localparam logic signed [RW-1:0] SAT_MIN =
                {{(RW - WIDTH_OUTPUT + 1){1'b1}}, {(WIDTH_OUTPUT - 1){1'b0}}};

            always_comb begin
                result = rounded[WIDTH_OUTPUT-1:0];
                if (rounded > SAT_MAX) begin
                    result = SAT_MAX[WIDTH_OUTPUT-1:0];
                end else if (rounded < SAT_MIN) begin
                    result = SAT_MIN[WIDTH_OUTPUT-1:0];
                end
            end
        end
    endgenerate
`else
    assign result = WIDTH_OUTPUT'(rounded);
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            o_dqvalid <= 1'b0;
            o_dqout   <= '0;
            done_o    <= 1'b0;
            cnt       <= '0;
        end else if (i_clear) begin
            o_dqvalid <= 1'b0;
            o_dqout   <= '0;
            done_o    <= 1'b0;
            cnt       <= '0;
        end else begin
            o_dqvalid <= s1_valid;
            if (s1_valid) begin
                o_dqout <= result;
                done_o  <= (cnt == LAST);
                cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end else begin
                o_dqout <= '0;
                done_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dequantize.sv
// Testbench for dequantize: default, fractional-scale and narrow-output instances
// share one stimulus stream.
module tb_dequantize;

    logic              clk;
    logic              rstn;
    logic              dq_valid;
    logic              clear;
    logic signed [7:0] din;

    logic signed [31:0] dout;
    logic               dvalid;
    logic               done;
    logic signed [31:0] dout_f;
    logic               dvalid_f;
    logic               done_f;
    logic signed [15:0] dout_w;
    logic               dvalid_w;
    logic               done_w;

    int errors = 0;
    int checks = 0;

    dequantize dut (
        .clk_i(clk), .rstn_i(rstn), .i_dq_valid(dq_valid), .i_clear(clear),
        .din_i(din), .o_dqout(dout), .o_dqvalid(dvalid), .done_o(done)
    );

    dequantize #(.SCALING_FACTOR(40), .FRAC_BITS(4)) u_frac (
        .clk_i(clk), .rstn_i(rstn), .i_dq_valid(dq_valid), .i_clear(clear),
        .din_i(din), .o_dqout(dout_f), .o_dqvalid(dvalid_f), .done_o(done_f)
    );

    dequantize #(.WIDTH_OUTPUT(16)) u_w16 (
        .clk_i(clk), .rstn_i(rstn), .i_dq_valid(dq_valid), .i_clear(clear),
        .din_i(din), .o_dqout(dout_w), .o_dqvalid(dvalid_w), .done_o(done_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        dq_valid = 1'b0;
        step();
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        clear    = 1'b0;
        dq_valid = 1'b1;
        din      = 8'sd5;
        #2;
        checks++;
        if (dvalid !== 1'b0 || dout !== 32'sd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid=%b dout=%0d done=%b required 0/0/0", dvalid, dout, done);
        end
        step();
        step();
        checks++;
        if (dvalid !== 1'b0 || dvalid_f !== 1'b0 || dvalid_w !== 1'b0 || dout !== 32'sd0) begin
            errors++;
            $display("FAIL reset_held: valid=%b/%b/%b dout=%0d required all 0", dvalid, dvalid_f, dvalid_w, dout);
        end
        rstn     = 1'b1;
        dq_valid = 1'b0;
        step();
        checks++;
        if (dvalid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: valid=%b done=%b required 0/0", dvalid, done);
        end
    endtask

    task automatic test_scaling();
        logic signed [7:0]  vin  [3] = '{8'sd5, -8'sd128, 8'sd127};
        logic signed [31:0] vexp [3] = '{32'sd12040, -32'sd308224, 32'sd305816};
        do_clear();
        for (int i = 0; i < 3; i++) begin
            din      = vin[i];
            dq_valid = 1'b1;
            step();
            dq_valid = 1'b0;
            din      = 8'sd0;
            checks++;
            if (dvalid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early[%0d]: valid=%b required 0", i, dvalid);
            end
            step();
            checks++;
            if (dvalid !== 1'b1 || dout !== vexp[i]) begin
                errors++;
                $display("FAIL scale[%0d]: valid=%b dout=%0d required 1/%0d", i, dvalid, dout, vexp[i]);
            end
            step();
            checks++;
            if (dvalid !== 1'b0 || dout !== 32'sd0) begin
                errors++;
                $display("FAIL idle_zero[%0d]: valid=%b dout=%0d required 0/0", i, dvalid, dout);
            end
        end
    endtask

    task automatic test_rounding();
        logic signed [7:0]  vin  [6] = '{8'sd3, -8'sd3, 8'sd2, 8'sd1, -8'sd1, 8'sd7};
        logic signed [31:0] vexp [6] = '{32'sd8, -32'sd8, 32'sd5, 32'sd3, -32'sd3, 32'sd18};
        do_clear();
        for (int i = 0; i < 6; i++) begin
            din      = vin[i];
            dq_valid = 1'b1;
            step();
            dq_valid = 1'b0;
            step();
            checks++;
            if (dvalid_f !== 1'b1 || dout_f !== vexp[i]) begin
                errors++;
                $display("FAIL round[%0d]: valid=%b dout=%0d required 1/%0d", i, dvalid_f, dout_f, vexp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [7:0]  vin  [2] = '{8'sd127, -8'sd128};
`ifdef DEQUANTIZE_SAT_EN
        logic signed [15:0] vexp [2] = '{16'sd32767, -16'sd32768};
`else
        logic signed [15:0] vexp [2] = '{-16'sd21864, 16'sd19456};
`endif
        do_clear();
        for (int i = 0; i < 2; i++) begin
            din      = vin[i];
            dq_valid = 1'b1;
            step();
            dq_valid = 1'b0;
            step();
            checks++;
            if (dvalid_w !== 1'b1 || dout_w !== vexp[i]) begin
                errors++;
                $display("FAIL narrow[%0d]: valid=%b dout=%0d required 1/%0d", i, dvalid_w, dout_w, vexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic               pat [21];
        logic               exp_v;
        logic               exp_done;
        logic signed [31:0] exp_d;
        int                 exp_cnt = 0;
        int                 nv = 0;
        int                 nd = 0;
        for (int k = 0; k < 21; k++) pat[k] = (k < 18) && (k != 2) && (k != 6);
        do_clear();
        for (int k = 0; k < 21; k++) begin
            dq_valid = pat[k];
            din      = 8'(k + 1);
            step();
            if (k >= 1) begin
                exp_v    = pat[k-1];
                exp_d    = exp_v ? 32'(k * 2408) : 32'sd0;
                exp_done = exp_v && (exp_cnt == 7);
                if (exp_v) exp_cnt = (exp_cnt + 1) % 8;
                if (dvalid === 1'b1) nv++;
                if (done === 1'b1) nd++;
                checks++;
                if (dvalid !== exp_v || dout !== exp_d || done !== exp_done) begin
                    errors++;
                    $display("FAIL burst[%0d]: valid=%b dout=%0d done=%b required %b/%0d/%b",
                             k, dvalid, dout, done, exp_v, exp_d, exp_done);
                end
            end
        end
        dq_valid = 1'b0;
        checks++;
        if (nv != 16 || nd != 2) begin
            errors++;
            $display("FAIL burst_totals: valids=%0d dones=%0d required 16/2", nv, nd);
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        for (int k = 0; k < 5; k++) begin
            dq_valid = 1'b1;
            din      = 8'(k + 1);
            step();
        end
        dq_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (dvalid !== 1'b0 || dout !== 32'sd0 || done !== 1'b0 || dvalid_f !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b dout=%0d done=%b required 0/0/0", dvalid, dout, done);
        end
        step();
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            dq_valid = (k < 8);
            din      = 8'(k + 1);
            step();
            if (k >= 1) begin
                checks++;
                if (dvalid !== (k <= 8) || done !== (k == 8)) begin
                    errors++;
                    $display("FAIL after_reset[%0d]: valid=%b done=%b required %b/%b",
                             k, dvalid, done, (k <= 8), (k == 8));
                end
            end
        end
        dq_valid = 1'b0;
    endtask

    task automatic test_clear_mid();
        do_clear();
        for (int k = 0; k < 5; k++) begin
            dq_valid = 1'b1;
            din      = 8'(k + 1);
            step();
        end
        clear    = 1'b1;
        dq_valid = 1'b1;
        din      = 8'sd99;
        step();
        checks++;
        if (dvalid !== 1'b0 || dout !== 32'sd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clear_edge: valid=%b dout=%0d done=%b required 0/0/0", dvalid, dout, done);
        end
        clear    = 1'b0;
        dq_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (dvalid !== 1'b0 || dout !== 32'sd0) begin
                errors++;
                $display("FAIL clear_drop[%0d]: valid=%b dout=%0d required 0/0", k, dvalid, dout);
            end
        end
        for (int k = 0; k < 10; k++) begin
            dq_valid = (k < 8);
            din      = 8'(k + 1);
            step();
            if (k >= 1) begin
                checks++;
                if (dvalid !== (k <= 8) || done !== (k == 8) || done_w !== (k == 8)) begin
                    errors++;
                    $display("FAIL after_clear[%0d]: valid=%b done=%b required %b/%b",
                             k, dvalid, done, (k <= 8), (k == 8));
                end
            end
        end
        dq_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scaling();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_clear_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
